// File: rtl/conv_acc_seq_if.sv
// Stream interface for conv_acc_seq: product input stream and result output
// stream. The slave modport is the accumulator's view; master is the view
// of the logic surrounding it (multiplier array feeding in, writer draining out).
interface conv_acc_seq_if #(
   parameter int DATA_W = 8
) ();
   logic                  in_valid;
   logic                  in_ready;
   logic [2*DATA_W-1:0]   in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_W-1:0]     out_data;
   logic                  ovf;

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output ovf
   );

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  ovf
   );
endinterface

// File: rtl/conv_acc_seq.sv
// conv_acc_seq: bias preload, product accumulation, scale/saturate and
// result handoff for one convolution output pixel.
// Optional build macro CONV_ACC_RELU_EN: clamp negative results to zero
// after saturation (ovf keeps the saturation outcome).
//
// state | meaning
// IDLE  | waiting for start; cfg_len and bias latched on start
// ACCUM | accepting products until cfg_len terms have been summed
// SAT   | one cycle: scale the sum down and clip it to DATA_W bits
// OUT   | holding the result until out_ready

`ifndef IMG_DATA_WIDTH
`define IMG_DATA_WIDTH 8
`endif

module conv_acc_seq #(
   parameter int DATA_W = `IMG_DATA_WIDTH,
   parameter int LEN_W  = 8,
   parameter int SHIFT  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic [DATA_W-1:0] bias,
   output logic              busy,
   conv_acc_seq_if.slave     bus
);

   // LEN_W guard bits: up to 2^LEN_W-1 full-scale products plus the bias
   // can never overflow the sum.
   localparam int ACC_W = 2*DATA_W + LEN_W;
   localparam logic signed [ACC_W-1:0] R_MAX =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] R_MIN =
      {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ACCUM, SAT, OUT} state_t;

   state_t                  state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [LEN_W-1:0]        count_q, count_d;
   logic [LEN_W-1:0]        len_q, len_d;
   logic [DATA_W-1:0]       out_data_q, out_data_d;
   logic                    ovf_q, ovf_d;

   logic                    in_fire;
   logic                    last_term;
   logic signed [ACC_W-1:0] bias_ext;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] r_shr;
   logic [DATA_W-1:0]       sat_val;
   logic                    sat_ovf;

   assign in_fire   = (state_q == ACCUM) && bus.in_valid;
   assign last_term = (count_q == (len_q - 1'b1));
   assign bias_ext  = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} <<< SHIFT;
   assign prod_ext  = {{(ACC_W-2*DATA_W){bus.in_data[2*DATA_W-1]}}, bus.in_data};
   assign r_shr     = acc_q >>> SHIFT;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (start) state_d = (cfg_len != '0) ? ACCUM : SAT;
         ACCUM: if (in_fire && last_term) state_d = SAT;
         SAT:   state_d = OUT;
         OUT:   if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs decoded from the current state
   always_comb begin
      busy          = (state_q != IDLE);
      bus.in_ready  = (state_q == ACCUM);
      bus.out_valid = (state_q == OUT);
   end

   // Scale and clip the sum; the clamp to zero, when built in, runs after
   // clipping so ovf still reports a negative saturation.
   always_comb begin
      sat_val = r_shr[DATA_W-1:0];
      sat_ovf = 1'b0;
      if (r_shr > R_MAX) begin
         sat_val = {1'b0, {(DATA_W-1){1'b1}}};
         sat_ovf = 1'b1;
      end else if (r_shr < R_MIN) begin
         sat_val = {1'b1, {(DATA_W-1){1'b0}}};
         sat_ovf = 1'b1;
      end
`ifdef CONV_ACC_RELU_EN
      if (sat_val[DATA_W-1]) sat_val = '0;
`else
`endif
   end

   // Datapath next values: preload, accumulate, capture result
   always_comb begin
      acc_d      = acc_q;
      count_d    = count_q;
      len_d      = len_q;
      out_data_d = out_data_q;
      ovf_d      = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               acc_d   = bias_ext;
               count_d = '0;
               len_d   = cfg_len;
            end
         end
         ACCUM: begin
            if (in_fire) begin
               acc_d   = acc_q + prod_ext;
               count_d = count_q + 1'b1;
            end
         end
         SAT: begin
            out_data_d = sat_val;
            ovf_d      = sat_ovf;
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q      <= '0;
         count_q    <= '0;
         len_q      <= '0;
         out_data_q <= '0;
         ovf_q      <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         count_q    <= count_d;
         len_q      <= len_d;
         out_data_q <= out_data_d;
         ovf_q      <= ovf_d;
      end
   end

   assign bus.out_data = out_data_q;
   assign bus.ovf      = ovf_q;

endmodule
